// File: rtl/rom_scroll_ctrl_pkg.sv
// Shared types and constants for the display-ROM scroll sequencer.
// Imported by rom_scroll_ctrl (optional feature macro: SCROLL_REVERSE_EN) and dwell_timer.
package rom_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CAPT  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam int SEG_W      = 7;
  localparam int SEG_HI_MSB = 13;
  localparam int SEG_HI_LSB = 7;
  localparam int SEG_LO_MSB = 6;
  localparam int SEG_LO_LSB = 0;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  // Register width needed to hold 0..n-1; a single-value range still needs one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_scroll_ctrl_if.sv
// ROM read port plus seven-segment output bundle between the sequencer and its neighbours.
interface rom_scroll_ctrl_if
  import rom_disp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs;
  logic [DATA_W-1:0] rom_data;
  logic [SEG_W-1:0]  seg_hi;
  logic [SEG_W-1:0]  seg_lo;
  logic              word_valid;
  logic              wrap;

  modport master (
    output rom_addr, rom_cs, seg_hi, seg_lo, word_valid, wrap,
    input  rom_data
  );

  modport slave (
    input  rom_addr, rom_cs, seg_hi, seg_lo, word_valid, wrap,
    output rom_data
  );

endinterface

// File: rtl/rom_scroll_ctrl_dwell_timer.sv
// Dwell counter for the scroll sequencer: counts enabled cycles and flags the last one.
module dwell_timer
  import rom_disp_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int            CW   = width_of(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      // Roll over on the terminal cycle so the count never leaves its range.
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign done = (count == LAST) && en;

endmodule

// File: rtl/rom_scroll_ctrl.sv
// Walks a message in the display ROM and drives two 7-segment digit patterns.
// Optional macro SCROLL_REVERSE_EN adds the dir input for backward scrolling.
//
// state | meaning
// IDLE  | waiting for run
// FETCH | rom_cs high, ROM samples rom_addr
// CAPT  | ROM output valid, captured into seg registers at the edge
// SHOW  | word displayed, dwell counter runs while run=1
module rom_scroll_ctrl
  import rom_disp_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BASE_ADDR = 0,
  parameter int MSG_LEN   = 6,
  parameter int DWELL     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
`ifdef SCROLL_REVERSE_EN
  input  logic dir,
`endif
  rom_scroll_ctrl_if.master bus
);

  localparam int            IW       = width_of(MSG_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt, step_idx;
  logic              step_wrap;
  logic              adv;
  logic              dwell_done;
  logic              capture;
  logic              wrap_pend;
  logic [ADDR_W-1:0] addr_q;
  logic [SEG_W-1:0]  seg_hi_q, seg_lo_q;
  logic              word_valid_q, wrap_q;
  logic              data_unused;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart || (state == CAPT)),
    .en   (run && (state == SHOW)),
    .done (dwell_done)
  );

  always_comb begin
    step_wrap = (idx == LAST_IDX);
    step_idx  = step_wrap ? '0 : idx + 1'b1;
`ifdef SCROLL_REVERSE_EN
    if (dir) begin
      step_wrap = (idx == '0);
      step_idx  = step_wrap ? LAST_IDX : idx - 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    adv       = 1'b0;
    if (restart) begin
      state_nxt = FETCH;
      idx_nxt   = '0;
    end else begin
      unique case (state)
        IDLE:  if (run) state_nxt = FETCH;
        FETCH: state_nxt = CAPT;
        CAPT:  state_nxt = SHOW;
        SHOW: begin
          if (dwell_done) begin
            adv       = 1'b1;
            idx_nxt   = step_idx;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A restart landing on the capture edge abandons that word in favour of word 0.
  assign capture = (state == CAPT) && !restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      addr_q       <= ADDR_W'(BASE_ADDR);
      seg_hi_q     <= '0;
      seg_lo_q     <= '0;
      word_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_pend    <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      addr_q       <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_nxt);
      word_valid_q <= capture;
      wrap_q       <= capture && wrap_pend;
      if (capture) begin
        seg_hi_q <= bus.rom_data[SEG_HI_MSB:SEG_HI_LSB];
        seg_lo_q <= bus.rom_data[SEG_LO_MSB:SEG_LO_LSB];
      end
      if (restart)      wrap_pend <= 1'b0;
      else if (adv)     wrap_pend <= step_wrap;
      else if (capture) wrap_pend <= 1'b0;
    end
  end

  assign data_unused    = ^bus.rom_data[DATA_W-1:SEG_HI_MSB+1];

  assign bus.rom_addr   = addr_q;
  assign bus.rom_cs     = (state == FETCH);
  assign bus.seg_hi     = seg_hi_q;
  assign bus.seg_lo     = seg_lo_q;
  assign bus.word_valid = word_valid_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_rom_scroll_ctrl.sv
// Directed bench for rom_scroll_ctrl: a 6-word/DWELL=4 instance and a 1-word/DWELL=1 instance.
module tb_rom_scroll_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic restart = 1'b0;
  logic run1 = 1'b0;
  logic restart1 = 1'b0;
`ifdef SCROLL_REVERSE_EN
  logic dir = 1'b0;
  logic dir1 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom_scroll_ctrl_if #(.ADDR_W(10), .DATA_W(16)) bus0 ();
  rom_scroll_ctrl_if #(.ADDR_W(10), .DATA_W(16)) bus1 ();

  rom_scroll_ctrl #(.ADDR_W(10), .DATA_W(16), .BASE_ADDR(0), .MSG_LEN(6), .DWELL(4)) dut0 (
    .clk(clk), .rst(rst), .run(run), .restart(restart),
`ifdef SCROLL_REVERSE_EN
    .dir(dir),
`endif
    .bus(bus0)
  );

  rom_scroll_ctrl #(.ADDR_W(10), .DATA_W(16), .BASE_ADDR(5), .MSG_LEN(1), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .restart(restart1),
`ifdef SCROLL_REVERSE_EN
    .dir(dir1),
`endif
    .bus(bus1)
  );

  logic [6:0]  hi_w [6] = '{7'b0000110, 7'h5B, 7'h66, 7'h7D, 7'h7F, 7'h77};
  logic [6:0]  lo_w [6] = '{7'b1001111, 7'h4F, 7'h6D, 7'h07, 7'h6F, 7'h39};
  logic [15:0] mem  [16];

  // Registered ROM: data appears the cycle after a cs-high cycle.
  always @(posedge clk) begin
    if (bus0.rom_cs) bus0.rom_data <= mem[bus0.rom_addr[3:0]];
    if (bus1.rom_cs) bus1.rom_data <= mem[bus1.rom_addr[3:0]];
  end

  typedef struct {
    logic       run;
    logic       cs;
    logic [9:0] addr;
    logic [6:0] hi;
    logic [6:0] lo;
    logic       wv;
    logic       wrap;
  } vec_t;

  vec_t tbl [41];

  function automatic logic [26:0] pk(input logic cs, input logic [9:0] addr,
                                     input logic [6:0] hi, input logic [6:0] lo,
                                     input logic wv, input logic wr);
    return {cs, addr, hi, lo, wv, wr};
  endfunction

  function automatic logic [26:0] obs0();
    return {bus0.rom_cs, bus0.rom_addr, bus0.seg_hi, bus0.seg_lo, bus0.word_valid, bus0.wrap};
  endfunction

  function automatic logic [26:0] obs1();
    return {bus1.rom_cs, bus1.rom_addr, bus1.seg_hi, bus1.seg_lo, bus1.word_valid, bus1.wrap};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input logic [9:0] a, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(bus0.rom_cs && bus0.rom_addr == a) && n < budget);
    chk("wait_fetch", {bus0.rom_cs, bus0.rom_addr}, {1'b1, a});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
    mem[0] = {2'b00, hi_w[0], lo_w[0]};
    for (int i = 1; i < 6; i++) mem[i] = {2'b11, hi_w[i], lo_w[i]};

    // Free-run expectations: period 6, FETCH at phase 0, display update at phase 2.
    for (int v = 0; v < 41; v++) begin
      int k, p, w, pw;
      k = v / 6;
      p = v % 6;
      w = k % 6;
      pw = (k + 5) % 6;
      tbl[v].run  = 1'b1;
      tbl[v].cs   = (p == 0);
      tbl[v].addr = 10'(w);
      if (p >= 2) begin
        tbl[v].hi = hi_w[w];
        tbl[v].lo = lo_w[w];
      end else if (k == 0) begin
        tbl[v].hi = 7'h00;
        tbl[v].lo = 7'h00;
      end else begin
        tbl[v].hi = hi_w[pw];
        tbl[v].lo = lo_w[pw];
      end
      tbl[v].wv   = (p == 2);
      tbl[v].wrap = (p == 2) && (k == 6);
    end

    repeat (2) step();
    chk("reset0", 32'(obs0()), 32'(pk(0, 10'd0, 7'h00, 7'h00, 0, 0)));
    chk("reset1", 32'(obs1()), 32'(pk(0, 10'd5, 7'h00, 7'h00, 0, 0)));
    rst = 1'b0;

    for (int v = 0; v < 41; v++) begin
      run = tbl[v].run;
      step();
      chk($sformatf("vec%0d", v), 32'(obs0()),
          32'(pk(tbl[v].cs, tbl[v].addr, tbl[v].hi, tbl[v].lo, tbl[v].wv, tbl[v].wrap)));
    end

    // Freeze in SHOW with two dwell cycles already spent.
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("freeze%0d", i), 32'(obs0()), 32'(pk(0, 10'd0, hi_w[0], lo_w[0], 0, 0)));
    end
    run = 1'b1;
    step();
    chk("resume_last", 32'(obs0()), 32'(pk(0, 10'd0, hi_w[0], lo_w[0], 0, 0)));
    step();
    chk("resume_fetch", 32'(obs0()), 32'(pk(1, 10'd1, hi_w[0], lo_w[0], 0, 0)));

    // Restart from word 3 while it is on display.
    wait_fetch(10'd3, 30);
    step();
    step();
    chk("show3", 32'(obs0()), 32'(pk(0, 10'd3, hi_w[3], lo_w[3], 1, 0)));
    step();
    restart = 1'b1;
    step();
    chk("restart_fetch", 32'(obs0()), 32'(pk(1, 10'd0, hi_w[3], lo_w[3], 0, 0)));
    restart = 1'b0;
    step();
    chk("restart_capt", 32'(obs0()), 32'(pk(0, 10'd0, hi_w[3], lo_w[3], 0, 0)));
    step();
    chk("restart_show", 32'(obs0()), 32'(pk(0, 10'd0, hi_w[0], lo_w[0], 1, 0)));

    // Async reset landing in CAPT.
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    chk("pre_rst_capt", 32'(obs0()), 32'(pk(0, 10'd0, hi_w[0], lo_w[0], 0, 0)));
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(obs0()), 32'(pk(0, 10'd0, 7'h00, 7'h00, 0, 0)));
    step();
    rst = 1'b0;
    step();
    chk("rst_refetch", 32'(obs0()), 32'(pk(1, 10'd0, 7'h00, 7'h00, 0, 0)));
    step();
    chk("rst_capt", 32'(obs0()), 32'(pk(0, 10'd0, 7'h00, 7'h00, 0, 0)));
    step();
    chk("rst_show", 32'(obs0()), 32'(pk(0, 10'd0, hi_w[0], lo_w[0], 1, 0)));

    // MSG_LEN=1, DWELL=1: period 3, wrap on every display after the first.
    run1 = 1'b1;
    for (int n = 0; n < 9; n++) begin
      logic wv;
      step();
      wv = (n % 3 == 2);
      chk($sformatf("len1_%0d", n), 32'(obs1()),
          32'(pk(n % 3 == 0, 10'd5, (n >= 2) ? hi_w[5] : 7'h00, (n >= 2) ? lo_w[5] : 7'h00,
                 wv, wv && (n >= 5))));
    end

`ifdef SCROLL_REVERSE_EN
    restart = 1'b1;
    dir = 1'b1;
    step();
    restart = 1'b0;
    wait_fetch(10'd5, 20);
    step();
    step();
    chk("rev_wrap", 32'(obs0()), 32'(pk(0, 10'd5, hi_w[5], lo_w[5], 1, 1)));
    wait_fetch(10'd4, 20);
    wait_fetch(10'd3, 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
